vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing generator for the pixel-clock domain. It produces HS/VS, the
//  active-video enable (pixelEN) and the pixel column/row address (addrH/addrV).
//  The top level consumes these: sync goes to the VGA pins, addresses go to the
//  lookupaddr/picrom path, and pixelEN gates R/G/B to black.
//  It also provides line/frame strobes and a frame counter for animation timing.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (clocks)
//  H_SYNC    96   horizontal sync width (clocks)
//  H_BP      48   horizontal back porch (clocks); H_TOTAL = sum = 800
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vertical sync width (lines)
//  V_BP      33   vertical back porch (lines); V_TOTAL = sum = 525
//  SYNC_POL  0    asserted level of HS/VS (0 = active-low, per 640x480@60)
// PORTS
//  vgaclk       in   1   pixel clock (25 MHz)
//  reset        in   1   asynchronous, active-high reset
//  en           in   1   count enable; 0 freezes counters and all outputs
//  HS           out  1   horizontal sync, level SYNC_POL when asserted
//  VS           out  1   vertical sync, level SYNC_POL when asserted
//  pixelEN      out  1   1 while (addrH,addrV) lies in the visible area
//  addrH        out  10  current column, 0..H_TOTAL-1
//  addrV        out  10  current row, 0..V_TOTAL-1
//  line_start   out  1   1-cycle pulse at addrH==0
//  frame_start  out  1   1-cycle pulse at addrH==0 && addrV==0
//  frame_cnt    out  6   frame counter, increments at each frame_start
// BEHAVIOUR
//  - State: h_cnt[9:0] and v_cnt[9:0], plus a registered output stage.
//    Every output is a flop. Outputs always show the decode of the counter
//    value from the previous enabled cycle (1-cycle latency, all aligned).
//  - Reset (async): h_cnt=v_cnt=0; HS=VS=~SYNC_POL; pixelEN=0; addrH=addrV=0;
//    line_start=frame_start=0; frame_cnt=0.
//  - Each edge with en=1:
//    * Output stage loads the decode of (h_cnt, v_cnt).
//    * h_cnt increments; at H_TOTAL-1 it wraps to 0.
//    * v_cnt increments only on the h wrap; at V_TOTAL-1 (with the h wrap) it
//      wraps to 0.
//  - Decode of (h,v):
//    * addrH=h, addrV=v.
//    * pixelEN = (h<H_ACTIVE) && (v<V_ACTIVE).
//    * HS asserted iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
//    * VS asserted iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491),
//      for whole lines, independent of h.
//    * line_start = (h==0); frame_start = (h==0 && v==0).
//  - frame_cnt increments by 1 (mod 64, 63->0) in the same edge that loads
//    frame_start=1.
//  - en=0: counters and all outputs hold their values. A pulse output that is
//    1 when en falls stays 1 until the next enabled edge.
//  - Reset mid-frame: immediate return to the reset values. Counting restarts
//    at (0,0), so the first enabled edge after release shows
//    addrH=0, addrV=0, pixelEN=1, line_start=frame_start=1, frame_cnt=1.
//  - Counters never exceed H_TOTAL-1 / V_TOTAL-1. Address widths are fixed at
//    10 bits; parameters with H_TOTAL or V_TOTAL > 1024 are illegal.
// TESTING
//  1 Assert reset, hold en=1 -> all outputs at reset values, HS=VS=1, no
//    toggling while reset=1.
//  2 Release reset, 1st edge -> addrH=0, addrV=0, pixelEN=1, frame_start=1,
//    frame_cnt=1. Edge 641 -> addrH=640, pixelEN=0.
//  3 Line timing -> HS low from edge 657 through edge 752 (96 clocks).
//    line_start period is 800 clocks.
//  4 Frame timing -> frame_start period is 420000 clocks. VS is low for
//    exactly 1600 clocks starting at addrV=490. pixelEN=1 for 307200 clocks
//    per frame.
//  5 Drop en for 37 clocks mid-line at addrH=300 -> all outputs frozen. Resume
//    -> addrH=301 on the next edge, and line period +37.
//  6 Pulse reset at addrV=200 -> outputs return to reset values at once.
//    Restart at (0,0). Run 64 frames -> frame_cnt wraps 63->0.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: the signals between the raster timing generator and
// whatever consumes it (sync pins, address lookup, pixel gating).
//   en          consumer -> generator   count enable, 0 freezes the raster
//   HS, VS      generator -> consumer   sync levels (SYNC_POL when asserted)
//   pixelEN     generator -> consumer   1 inside the visible area
//   addrH/addrV generator -> consumer   current column / row
//   line_start  generator -> consumer   pulse at column 0
//   frame_start generator -> consumer   pulse at column 0, row 0
//   frame_cnt   generator -> consumer   frame counter, mod 64
// There is no valid/ready pair: every output is meaningful on every cycle, and
// a new value is presented only on clock edges where en is 1.
interface vga_timing_gen_if;
    logic       en;
    logic       HS;
    logic       VS;
    logic       pixelEN;
    logic [9:0] addrH;
    logic [9:0] addrV;
    logic       line_start;
    logic       frame_start;
    logic [5:0] frame_cnt;

    modport master (
        input  en,
        output HS, VS, pixelEN, addrH, addrV, line_start, frame_start, frame_cnt
    );

    modport slave (
        output en,
        input  HS, VS, pixelEN, addrH, addrV, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the pixel clock domain.
// Two free-running counters (h_cnt, v_cnt) walk the full raster; every output
// is a flop loaded with the decode of the counters from the previous enabled
// cycle, so all outputs share the same one-cycle latency.
// Ports:
//   vgaclk  pixel clock
//   reset   asynchronous, active-high reset
//   vga     vga_timing_gen_if.master: en in; HS, VS, pixelEN, addrH, addrV,
//           line_start, frame_start, frame_cnt out
// H_TOTAL and V_TOTAL must not exceed 1024 (10-bit counters).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic              vgaclk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    // Decode of the current counter values; registered below.
    logic hs_on;
    logic vs_on;
    logic visible;
    logic at_h0;
    logic at_origin;
    logic h_wrap;
    logic v_wrap;

    always_comb begin
        hs_on     = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
        // VS covers whole lines, so it depends on the row only.
        vs_on     = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
        visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        at_h0     = (h_cnt == 10'd0);
        at_origin = at_h0 && (v_cnt == 10'd0);
        h_wrap    = (h_cnt == H_LAST);
        v_wrap    = (v_cnt == V_LAST);
    end

    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            vga.HS          <= ~SYNC_POL;
            vga.VS          <= ~SYNC_POL;
            vga.pixelEN     <= 1'b0;
            vga.addrH       <= '0;
            vga.addrV       <= '0;
            vga.line_start  <= 1'b0;
            vga.frame_start <= 1'b0;
            vga.frame_cnt   <= '0;
        end else if (vga.en) begin
            // Output stage: decode of the counters as they were before this edge.
            vga.HS          <= hs_on ? SYNC_POL : ~SYNC_POL;
            vga.VS          <= vs_on ? SYNC_POL : ~SYNC_POL;
            vga.pixelEN     <= visible;
            vga.addrH       <= h_cnt;
            vga.addrV       <= v_cnt;
            vga.line_start  <= at_h0;
            vga.frame_start <= at_origin;
            // frame_cnt steps on the same edge that raises frame_start.
            if (at_origin) begin
                vga.frame_cnt <= vga.frame_cnt + 6'd1;
            end

            // Raster counters.
            if (h_wrap) begin
                h_cnt <= '0;
                if (v_wrap) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. A full-size 640x480 instance covers line-level
// timing, enable freeze and pulse holding; a reduced-raster instance
// (15 x 9 clocks) covers frame-level timing, mid-frame reset and the
// frame counter wrap within a short run.
module tb_vga_timing_gen;
    logic clk;
    logic rst_d;
    logic rst_s;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    vga_timing_gen_if d_if ();
    vga_timing_gen_if s_if ();

    vga_timing_gen dut (
        .vgaclk (clk),
        .reset  (rst_d),
        .vga    (d_if.master)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .SYNC_POL (1'b0)
    ) dut_s (
        .vgaclk (clk),
        .reset  (rst_s),
        .vga    (s_if.master)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
    endtask

    // {HS, VS, pixelEN, line_start, frame_start, frame_cnt, addrV, addrH}
    function automatic logic [30:0] pack_d();
        return {d_if.HS, d_if.VS, d_if.pixelEN, d_if.line_start, d_if.frame_start,
                d_if.frame_cnt, d_if.addrV, d_if.addrH};
    endfunction

    function automatic logic [30:0] pack_s();
        return {s_if.HS, s_if.VS, s_if.pixelEN, s_if.line_start, s_if.frame_start,
                s_if.frame_cnt, s_if.addrV, s_if.addrH};
    endfunction

    localparam logic [30:0] RESET_VAL = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0, 10'd0};

    // ---------------- vector table ----------------
    typedef struct {
        int         n;     // enabled edge number after reset release
        logic [9:0] h;
        logic [9:0] v;
        logic       pix;
        logic       hs;
        logic       ls;
        logic       fs;
        logic [5:0] fc;
    } vec_t;

    vec_t tbl[13];

    // Scoreboard of expected frame_cnt values, one per frame_start.
    logic [5:0] exp_q[$];

    initial begin
        logic [30:0] snap;
        logic [30:0] want;
        int          per;
        int          hs_low;
        int          ls_seen;
        int          vs_low;
        int          pix_cnt;
        int          budget;
        logic [9:0]  vs_first_v;
        logic [9:0]  vs_first_h;
        logic        vs_seen;
        logic [5:0]  e;

        tbl[0]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd1};
        tbl[1]  = '{2,    10'd1,   10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1};
        tbl[2]  = '{640,  10'd639, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1};
        tbl[3]  = '{641,  10'd640, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1};
        tbl[4]  = '{656,  10'd655, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1};
        tbl[5]  = '{657,  10'd656, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1};
        tbl[6]  = '{752,  10'd751, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1};
        tbl[7]  = '{753,  10'd752, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1};
        tbl[8]  = '{800,  10'd799, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1};
        tbl[9]  = '{801,  10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd1};
        tbl[10] = '{802,  10'd1,   10'd1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1};
        tbl[11] = '{1441, 10'd640, 10'd1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1};
        tbl[12] = '{1601, 10'd0,   10'd2, 1'b1, 1'b1, 1'b1, 1'b0, 6'd1};

        rst_d = 1'b1;
        rst_s = 1'b1;
        d_if.en = 1'b1;
        s_if.en = 1'b1;

        // ---- reset held with en=1: outputs stay at reset values ----
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold_d", 32'(pack_d()), 32'(RESET_VAL));
            check("reset_hold_s", 32'(pack_s()), 32'(RESET_VAL));
        end

        rst_d = 1'b0;
        rst_s = 1'b0;
        n = 0;

        // ---- first line and start of the next lines, table-driven ----
        for (int k = 0; k < 13; k++) begin
            while (n < tbl[k].n) begin
                tick();
                n++;
            end
            want = {tbl[k].hs, 1'b1, tbl[k].pix, tbl[k].ls, tbl[k].fs,
                    tbl[k].fc, tbl[k].v, tbl[k].h};
            check($sformatf("vec%0d", k), 32'(pack_d()), 32'(want));
        end

        // ---- one full line: 96 HS-low clocks, one line_start ----
        hs_low  = 0;
        ls_seen = 0;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (d_if.HS == 1'b0) hs_low++;
            if (d_if.line_start) ls_seen++;
        end
        check("hs_low_clocks", 32'(hs_low), 32'd96);
        check("line_start_per_800", 32'(ls_seen), 32'd1);
        check("line3_origin", 32'({d_if.line_start, d_if.addrV, d_if.addrH}),
              32'({1'b1, 10'd3, 10'd0}));

        // ---- line_start held high while en is low ----
        d_if.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pulse_hold", 32'({d_if.line_start, d_if.addrH}), 32'({1'b1, 10'd0}));
        end
        d_if.en = 1'b1;
        tick();
        check("pulse_release", 32'({d_if.line_start, d_if.addrH}), 32'({1'b0, 10'd1}));

        // ---- freeze at addrH=300 for 37 clocks, line period grows by 37 ----
        budget = 2000;
        while (!d_if.line_start && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) timeout("wait_line_start");
        per = 0;
        budget = 1000;
        while (d_if.addrH != 10'd300 && budget > 0) begin
            tick();
            per++;
            budget--;
        end
        if (budget == 0) timeout("wait_h300");
        snap = pack_d();
        d_if.en = 1'b0;
        for (int i = 0; i < 37; i++) begin
            tick();
            per++;
            check("freeze", 32'(pack_d()), 32'(snap));
        end
        d_if.en = 1'b1;
        tick();
        per++;
        check("resume_h", 32'(d_if.addrH), 32'd301);
        budget = 2000;
        while (!d_if.line_start && budget > 0) begin
            tick();
            per++;
            budget--;
        end
        if (budget == 0) timeout("wait_next_line");
        check("frozen_line_period", 32'(per), 32'd837);

        // ---- reduced raster: frame period, VS window, visible count ----
        budget = 500;
        while (!s_if.frame_start && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) timeout("wait_frame_s");
        per = 0;
        vs_low = 0;
        pix_cnt = 0;
        vs_seen = 1'b0;
        vs_first_v = '0;
        vs_first_h = '0;
        budget = 500;
        do begin
            tick();
            per++;
            budget--;
            if (s_if.VS == 1'b0) begin
                if (!vs_seen) begin
                    vs_first_v = s_if.addrV;
                    vs_first_h = s_if.addrH;
                end
                vs_seen = 1'b1;
                vs_low++;
            end
            if (s_if.pixelEN) pix_cnt++;
        end while (!s_if.frame_start && budget > 0);
        if (budget == 0) timeout("wait_frame_s2");
        check("frame_period", 32'(per), 32'd135);
        check("vs_low_clocks", 32'(vs_low), 32'd30);
        check("vs_start_pos", 32'({vs_first_v, vs_first_h}), 32'({10'd5, 10'd0}));
        check("pix_per_frame", 32'(pix_cnt), 32'd32);

        // ---- mid-frame reset at addrV=2 ----
        budget = 500;
        while (s_if.addrV != 10'd2 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) timeout("wait_v2");
        #2;
        rst_s = 1'b1;
        #1;
        check("reset_immediate", 32'(pack_s()), 32'(RESET_VAL));
        tick();
        check("reset_held", 32'(pack_s()), 32'(RESET_VAL));
        rst_s = 1'b0;
        tick();
        check("restart", 32'(pack_s()),
              32'({1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd1, 10'd0, 10'd0}));

        // ---- 63 more frames: frame_cnt runs 2..63 then wraps to 0 ----
        for (int k = 0; k < 63; k++) exp_q.push_back(6'((k + 2) % 64));
        budget = 63 * 135 + 200;
        while (exp_q.size() > 0 && budget > 0) begin
            tick();
            budget--;
            if (s_if.frame_start) begin
                e = exp_q.pop_front();
                check("frame_cnt", 32'(s_if.frame_cnt), 32'(e));
            end
        end
        if (exp_q.size() > 0) timeout("frame_cnt_frames");
        check("frame_cnt_wrap", 32'(s_if.frame_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
